nfc_stim_gen: RTL
=================

NFC_STIM_GEN -- requirements
Module: nfc_stim_gen

Interface
REQ-001 SHALL have parameter CARRIER_DIV, default 2: clk cycles per carrier half-period, at least 1.
REQ-002 SHALL have parameter BIT_DIV, default 8: clk cycles per data bit, at least 2.
REQ-003 SHALL have parameter FRAME_W, default 16: data bits per frame.
REQ-004 SHALL have parameter DEPTH, default 4: frame FIFO entries, power of two.
REQ-005 SHALL have parameter GAP_BITS, default 1: idle bit periods after each frame.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port frame_data, input, FRAME_W: frame payload, sent MSB first.
REQ-009 SHALL have port frame_dir, input, 1: 1 means the frame drives tx, 0 means it drives rx.
REQ-010 SHALL have port frame_valid, input, 1: producer offers a frame.
REQ-011 SHALL have port frame_ready, output, 1: FIFO can accept a frame.
REQ-012 SHALL have port carrier, output, 1: free-running square-wave carrier.
REQ-013 SHALL have ports tx and rx, outputs, 1 each: communication waveforms.
REQ-014 SHALL have port busy, output, 1: high in SEND or GAP.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at the end of each frame.

Function
REQ-016 A carrier counter SHALL count 0..CARRIER_DIV-1, and carrier SHALL toggle on the wrap; carrier first reads 1 exactly CARRIER_DIV cycles after rst deasserts, giving a period of 2*CARRIER_DIV cycles.
REQ-017 A frame SHALL be accepted on any cycle where frame_valid and frame_ready are both high; frame_ready SHALL equal not-full, independent of a same-cycle pop.
REQ-018 The FSM SHALL have three states: IDLE, SEND and GAP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one {dir, data} entry and enter SEND; the first bit SHALL appear on tx or rx on the cycle after the pop, so a push into an empty idle block shows its first bit 2 cycles after acceptance.
REQ-020 In SEND, each bit SHALL be held for BIT_DIV cycles. The selected line (tx if dir=1, else rx) SHALL carry the bit, and the other line SHALL stay 0.
REQ-021 After FRAME_W bits, done SHALL pulse for one cycle and the FSM SHALL enter GAP, holding tx=rx=0 for GAP_BITS*BIT_DIV cycles; with GAP_BITS=0 the FSM SHALL skip GAP.
REQ-022 When GAP ends, the FSM SHALL go to IDLE, which pops in the same cycle if the FIFO is non-empty; it SHALL NOT insert an extra idle cycle.
REQ-023 Counters SHALL be $clog2-sized and SHALL wrap only at their terminal counts.
REQ-024 tx, rx and carrier SHALL be registered outputs.

Reset
REQ-025 rst SHALL clear, on the next edge: carrier, tx, rx, busy and done to 0; frame_ready to 1; the FIFO to empty; all counters to 0; the FSM to IDLE.
REQ-026 rst in mid-frame SHALL discard the current frame and all queued frames, with no done pulse.

Configuration
REQ-027 With NFC_STIM_MANCHESTER_EN defined, each bit SHALL be Manchester-coded: bit 1 is high for BIT_DIV/2 cycles then low, bit 0 is low then high. BIT_DIV SHALL be even, checked by an elaboration assertion.
REQ-028 Without NFC_STIM_MANCHESTER_EN, the output SHALL be NRZ, with the bit level held for the full BIT_DIV cycles.

Structure
REQ-029 Package nfc_stim_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-030 The FIFO SHALL be sub-module nfc_stim_fifo, parameterised on width FRAME_W+1 and DEPTH, with push, pop, full, empty and rd_data.

Verification (CARRIER_DIV=2, BIT_DIV=8, FRAME_W=8, DEPTH=2, GAP_BITS=1)
REQ-031 Reset held 3 cycles -> carrier=tx=rx=busy=done=0 and frame_ready=1.
REQ-032 Free-run after reset -> carrier reads 0,0,1,1,0,0,1,1...; the first 1 is at cycle 2.
REQ-033 Push 0xA5 with dir=1 -> tx is 1,0,1,0,0,1,0,1 for 8 cycles per bit, starting 2 cycles after acceptance, rx=0 throughout; done pulses after 64 bit cycles; then 8 gap cycles; then busy=0.
REQ-034 Push 4 frames back-to-back -> first frame popped, two queued, frame_ready=0 with the fourth stalled until the next pop; all frames emitted in order with 8-cycle gaps; dir=0 frames appear only on rx.
REQ-035 Assert rst at bit 3 of a frame with 2 queued -> next cycle tx=rx=busy=0, FIFO empty, no done pulse.
REQ-036 With NFC_STIM_MANCHESTER_EN, push 0x80 with dir=1 -> tx high 4 cycles then low 4 cycles, followed by seven repeats of low 4 then high 4.

Source files
------------

// File: rtl/nfc_stim_pkg.sv
// Shared types and default parameters for the NFC stimulus generator.
// Optional build macro: NFC_STIM_MANCHESTER_EN (Manchester bit coding).
package nfc_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } nfc_state_t;

    localparam int CARRIER_DIV_DEF = 2;
    localparam int BIT_DIV_DEF     = 8;
    localparam int FRAME_W_DEF     = 16;
    localparam int DEPTH_DEF       = 4;
    localparam int GAP_BITS_DEF    = 1;

    // Counter width that stays legal when the terminal count is 0 or 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nfc_stim_fifo.sv
// Frame FIFO holding {dir, data} entries; read data is shown combinationally at the head.
module nfc_stim_fifo
    import nfc_stim_pkg::*;
#(
    parameter int WIDTH = FRAME_W_DEF + 1,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = cnt_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            if (do_pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/nfc_stim_gen.sv
// NFC stimulus generator: free-running carrier plus queued frames serialised MSB first onto tx or rx.
// Build macro NFC_STIM_MANCHESTER_EN selects Manchester coding instead of NRZ.
module nfc_stim_gen
    import nfc_stim_pkg::*;
#(
    parameter int CARRIER_DIV = CARRIER_DIV_DEF,
    parameter int BIT_DIV     = BIT_DIV_DEF,
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int GAP_BITS    = GAP_BITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic               frame_dir,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic               carrier,
    output logic               tx,
    output logic               rx,
    output logic               busy,
    output logic               done,
    output nfc_state_t         fsm_state
);
    localparam int CW      = cnt_w(CARRIER_DIV);
    localparam int DW      = cnt_w(BIT_DIV);
    localparam int BW      = cnt_w(FRAME_W);
    localparam int GAP_CYC = GAP_BITS * BIT_DIV;
    localparam int GW      = cnt_w(GAP_CYC);

    localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

`ifdef NFC_STIM_MANCHESTER_EN
    localparam logic [DW-1:0] HALF = DW'(BIT_DIV / 2);
    if (BIT_DIV % 2 != 0) begin : g_bit_div_even
        $error("nfc_stim_gen: BIT_DIV must be even for Manchester coding");
    end
`endif

    logic [CW-1:0]      car_cnt;
    nfc_state_t         state, state_n;
    logic [DW-1:0]      div_cnt, div_n;
    logic [BW-1:0]      bit_cnt, bit_n;
    logic [GW-1:0]      gap_cnt, gap_n;
    logic [FRAME_W-1:0] shreg, sh_n;
    logic               dir_r, dir_n;
    logic               lvl, drive, line_n, done_n;
    logic               push, pop, full, empty;
    logic [FRAME_W:0]   rd_data;

    assign frame_ready = !full;
    assign push        = frame_valid && frame_ready;
    assign busy        = (state != ST_IDLE);
    assign fsm_state   = state;

    nfc_stim_fifo #(.WIDTH(FRAME_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data ({frame_dir, frame_data}),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            car_cnt <= '0;
            carrier <= 1'b0;
        end else if (car_cnt == CAR_LAST) begin
            car_cnt <= '0;
            carrier <= ~carrier;
        end else begin
            car_cnt <= car_cnt + 1'b1;
        end
    end

    // Next-cycle line level is computed here so tx/rx leave a flop.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        sh_n    = shreg;
        dir_n   = dir_r;
        lvl     = 1'b0;
        drive   = 1'b0;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = ST_SEND;
                    sh_n    = rd_data[FRAME_W-1:0];
                    dir_n   = rd_data[FRAME_W];
                    div_n   = '0;
                    bit_n   = '0;
                    lvl     = rd_data[FRAME_W-1];
                    drive   = 1'b1;
                end
            end
            ST_SEND: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        done_n  = 1'b1;
                        bit_n   = '0;
                        state_n = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                        sh_n  = shreg << 1;
                        lvl   = sh_n[FRAME_W-1];
                        drive = 1'b1;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                    lvl   = shreg[FRAME_W-1];
                    drive = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef NFC_STIM_MANCHESTER_EN
        line_n = drive & ((div_n < HALF) ? lvl : ~lvl);
`else
        line_n = drive & lvl;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            dir_r   <= 1'b0;
            tx      <= 1'b0;
            rx      <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            gap_cnt <= gap_n;
            shreg   <= sh_n;
            dir_r   <= dir_n;
            tx      <= dir_n & line_n;
            rx      <= ~dir_n & line_n;
            done    <= done_n;
        end
    end

endmodule
